// File: rtl/tl_tx_flow_control_credit_gate.sv
// tl_tx_flow_control_credit_gate: PCIe TL TX credit gate. Holds far-end FC limits and consumed
// counts per P/NP/CPL and admits a TLP only when header and data credits remain (modulo gating).
module tl_tx_flow_control_credit_gate #(
    parameter int FC_HDR_CREDS_WIDTH  = 12,
    parameter int FC_DATA_CREDS_WIDTH = 16,
    parameter int REQ_DATA_WIDTH      = 10
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           dll_link_up,
    input  logic                           dll_valid,
    input  logic                           dll_fc_init,
    input  logic [1:0]                     dll_typ,
    input  logic [FC_HDR_CREDS_WIDTH-1:0]  dll_hdr_creds,
    input  logic [FC_DATA_CREDS_WIDTH-1:0] dll_data_creds,
    input  logic [1:0]                     dll_hdr_scale,
    input  logic [1:0]                     dll_data_scale,
    input  logic                           tlp_req_valid,
    input  logic [1:0]                     tlp_req_typ,
    input  logic [REQ_DATA_WIDTH-1:0]      tlp_req_data_creds,
    output logic                           tlp_req_ready,
    output logic                           fc_init_done,
    output logic                           fc_update_error
);
    localparam int HCLW = FC_HDR_CREDS_WIDTH + 4;
    localparam int DCLW = FC_DATA_CREDS_WIDTH + 4;
    localparam logic [1:0] FC_IDLE   = 2'd0;
    localparam logic [1:0] FC_INIT   = 2'd1;
    localparam logic [1:0] FC_ACTIVE = 2'd2;
    localparam logic [HCLW-1:0] H_HALF = {1'b1, {(HCLW-1){1'b0}}};
    localparam logic [DCLW-1:0] D_HALF = {1'b1, {(DCLW-1){1'b0}}};

    logic [1:0]      r_state;
    logic [HCLW-1:0] r_hdr_cl  [3];
    logic [HCLW-1:0] r_hdr_cc  [3];
    logic [DCLW-1:0] r_data_cl [3];
    logic [DCLW-1:0] r_data_cc [3];
    logic [2:0]      r_hdr_inf;
    logic [2:0]      r_data_inf;
    logic [2:0]      r_init_rcvd;
    logic            r_done;
    logic            r_err;

    logic [2:0]      w_hdr_sh;
    logic [2:0]      w_data_sh;
    logic [HCLW-1:0] w_hdr_lim;
    logic [HCLW-1:0] w_hdr_room;
    logic [HCLW-1:0] w_hdr_cc_post;
    logic [DCLW-1:0] w_data_lim;
    logic [DCLW-1:0] w_data_room;
    logic [DCLW-1:0] w_data_cc_post;
    logic [DCLW-1:0] w_req;
    logic            w_active;
    logic            w_hdr_ok;
    logic            w_data_ok;
    logic            w_ready;
    logic            w_same;
    logic            w_clr;
    logic            w_init;
    logic            w_upd;
    logic            w_hdr_bad;
    logic            w_data_bad;
    logic            w_hdr_load;
    logic            w_data_load;

    always_comb begin
        w_hdr_sh       = dll_hdr_scale[1] ? (dll_hdr_scale[0] ? 3'd4 : 3'd2) : 3'd0;
        w_data_sh      = dll_data_scale[1] ? (dll_data_scale[0] ? 3'd4 : 3'd2) : 3'd0;
        w_hdr_lim      = {4'b0, dll_hdr_creds} << w_hdr_sh;
        w_data_lim     = {4'b0, dll_data_creds} << w_data_sh;
        w_req          = {{(DCLW-REQ_DATA_WIDTH){1'b0}}, tlp_req_data_creds};
        w_active       = r_state == FC_ACTIVE;
        // Remaining-credit distance; anything past half the ring means the request overruns the limit
        w_hdr_room     = r_hdr_cl[tlp_req_typ] - (r_hdr_cc[tlp_req_typ] + HCLW'(1));
        w_data_room    = r_data_cl[tlp_req_typ] - (r_data_cc[tlp_req_typ] + w_req);
        w_hdr_ok       = r_hdr_inf[tlp_req_typ] | (w_hdr_room <= H_HALF);
        w_data_ok      = r_data_inf[tlp_req_typ] | (tlp_req_data_creds == '0) | (w_data_room <= D_HALF);
        w_ready        = tlp_req_valid & w_active & (tlp_req_typ != 2'd3) & w_hdr_ok & w_data_ok;
        // UpdateFC legality is judged against the count after this cycle's consume
        w_same         = w_ready & (tlp_req_typ == dll_typ);
        w_hdr_cc_post  = r_hdr_cc[dll_typ] + (w_same ? HCLW'(1) : '0);
        w_data_cc_post = r_data_cc[dll_typ] + (w_same ? w_req : '0);
        w_hdr_bad      = ~r_hdr_inf[dll_typ] & ((w_hdr_lim - w_hdr_cc_post) > H_HALF);
        w_data_bad     = ~r_data_inf[dll_typ] & ((w_data_lim - w_data_cc_post) > D_HALF);
        w_clr          = ~dll_link_up | (r_state == FC_IDLE);
        w_init         = dll_valid & dll_fc_init & (dll_typ != 2'd3) & (r_state == FC_INIT) & ~r_init_rcvd[dll_typ];
        w_upd          = dll_valid & ~dll_fc_init & (dll_typ != 2'd3) & w_active;
        w_hdr_load     = w_upd & ~r_hdr_inf[dll_typ] & ~w_hdr_bad;
        w_data_load    = w_upd & ~r_data_inf[dll_typ] & ~w_data_bad;
        tlp_req_ready  = w_ready;
        fc_init_done   = r_done;
        fc_update_error = r_err;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= FC_IDLE;
            r_hdr_cl    <= '{default: '0};
            r_hdr_cc    <= '{default: '0};
            r_data_cl   <= '{default: '0};
            r_data_cc   <= '{default: '0};
            r_hdr_inf   <= '0;
            r_data_inf  <= '0;
            r_init_rcvd <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_active;
            if (w_clr) begin
                r_state     <= dll_link_up ? FC_INIT : FC_IDLE;
                r_hdr_cl    <= '{default: '0};
                r_hdr_cc    <= '{default: '0};
                r_data_cl   <= '{default: '0};
                r_data_cc   <= '{default: '0};
                r_hdr_inf   <= '0;
                r_data_inf  <= '0;
                r_init_rcvd <= '0;
                r_err       <= 1'b0;
            end else begin
                r_err <= w_upd & (w_hdr_bad | w_data_bad);
                if (r_state == FC_INIT && &r_init_rcvd)
                    r_state <= FC_ACTIVE;
                if (w_init) begin
                    r_hdr_cl[dll_typ]    <= w_hdr_lim;
                    r_data_cl[dll_typ]   <= w_data_lim;
                    r_hdr_inf[dll_typ]   <= dll_hdr_creds == '0;
                    r_data_inf[dll_typ]  <= dll_data_creds == '0;
                    r_init_rcvd[dll_typ] <= 1'b1;
                end
                if (w_ready) begin
                    r_hdr_cc[tlp_req_typ]  <= r_hdr_cc[tlp_req_typ] + HCLW'(1);
                    r_data_cc[tlp_req_typ] <= r_data_cc[tlp_req_typ] + w_req;
                end
                if (w_hdr_load)
                    r_hdr_cl[dll_typ] <= w_hdr_lim;
                if (w_data_load)
                    r_data_cl[dll_typ] <= w_data_lim;
            end
        end
    end
endmodule

// File: tb/tb_tl_tx_flow_control_credit_gate.sv
// tb_tl_tx_flow_control_credit_gate: scenario tasks push expected ready/error into queues at drive
// time and pop them when the DUT output is sampled; data-credit width is narrowed to exercise wrap.
module tb_tl_tx_flow_control_credit_gate;
    localparam int HW = 12;
    localparam int DW = 8;
    localparam int RW = 10;

    logic          clk = 1'b0;
    logic          arst_n = 1'b1;
    logic          dll_link_up = 1'b0;
    logic          dll_valid = 1'b0;
    logic          dll_fc_init = 1'b0;
    logic [1:0]    dll_typ = '0;
    logic [HW-1:0] dll_hdr_creds = '0;
    logic [DW-1:0] dll_data_creds = '0;
    logic [1:0]    dll_hdr_scale = '0;
    logic [1:0]    dll_data_scale = '0;
    logic          tlp_req_valid = 1'b0;
    logic [1:0]    tlp_req_typ = '0;
    logic [RW-1:0] tlp_req_data_creds = '0;
    logic          tlp_req_ready;
    logic          fc_init_done;
    logic          fc_update_error;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   q_rdy[$];
    bit   q_err[$];
    logic [1:0] upd_ds = 2'b00;
    int   cons;
    int   lim;

    tl_tx_flow_control_credit_gate #(
        .FC_HDR_CREDS_WIDTH(HW), .FC_DATA_CREDS_WIDTH(DW), .REQ_DATA_WIDTH(RW)
    ) dut (
        .clk(clk), .arst_n(arst_n), .dll_link_up(dll_link_up), .dll_valid(dll_valid),
        .dll_fc_init(dll_fc_init), .dll_typ(dll_typ), .dll_hdr_creds(dll_hdr_creds),
        .dll_data_creds(dll_data_creds), .dll_hdr_scale(dll_hdr_scale),
        .dll_data_scale(dll_data_scale), .tlp_req_valid(tlp_req_valid),
        .tlp_req_typ(tlp_req_typ), .tlp_req_data_creds(tlp_req_data_creds),
        .tlp_req_ready(tlp_req_ready), .fc_init_done(fc_init_done),
        .fc_update_error(fc_update_error)
    );

    always #5 clk = ~clk;

    // One ACTIVE-state cycle: request + optional UpdateFC, ready checked mid-cycle, error after the edge
    task automatic tick(input logic v, input logic [1:0] t, input int req, input bit exp_r,
                        input logic uv, input logic [1:0] ut, input int uh, input int ud,
                        input bit exp_e, input string nm);
        bit er;
        bit ee;
        tlp_req_valid = v;
        tlp_req_typ = t;
        tlp_req_data_creds = RW'(req);
        dll_valid = uv;
        dll_fc_init = 1'b0;
        dll_typ = ut;
        dll_hdr_creds = HW'(uh);
        dll_data_creds = DW'(ud);
        dll_hdr_scale = 2'b00;
        dll_data_scale = upd_ds;
        q_rdy.push_back(exp_r);
        q_err.push_back(exp_e);
        @(negedge clk);
        er = q_rdy.pop_front();
        n_chk++;
        if (tlp_req_ready !== er) begin
            n_fail++;
            $display("FAIL %s ready: got %b expected %b", nm, tlp_req_ready, er);
        end
        @(posedge clk);
        #1;
        tlp_req_valid = 1'b0;
        dll_valid = 1'b0;
        ee = q_err.pop_front();
        n_chk++;
        if (fc_update_error !== ee) begin
            n_fail++;
            $display("FAIL %s update_error: got %b expected %b", nm, fc_update_error, ee);
        end
    endtask

    task automatic send_init(input logic [1:0] t, input int h, input int d,
                             input logic [1:0] hs, input logic [1:0] ds);
        dll_valid = 1'b1;
        dll_fc_init = 1'b1;
        dll_typ = t;
        dll_hdr_creds = HW'(h);
        dll_data_creds = DW'(d);
        dll_hdr_scale = hs;
        dll_data_scale = ds;
        @(posedge clk);
        #1;
        dll_valid = 1'b0;
        dll_fc_init = 1'b0;
    endtask

    // A second P InitFC carries junk that must be ignored
    task automatic fc_init(input int ph, input int pd, input int nh, input int nd,
                           input int ch, input int cd, input logic [1:0] phs, input logic [1:0] pds);
        int k;
        dll_link_up = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_init(2'd0, ph, pd, phs, pds);
        send_init(2'd0, 1, 1, 2'b00, 2'b00);
        send_init(2'd1, nh, nd, 2'b00, 2'b00);
        send_init(2'd2, ch, cd, 2'b00, 2'b00);
        k = 0;
        while (fc_init_done !== 1'b1 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_chk++;
        if (fc_init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done: got %b expected 1 within 10 cycles", fc_init_done);
        end
    endtask

    task automatic drop_link();
        dll_link_up = 1'b0;
        tlp_req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (fc_init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_link done: got %b expected 0", fc_init_done);
        end
    endtask

    task automatic test_reset();
        #2 arst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dll_link_up = 1'($urandom);
            dll_valid = 1'($urandom);
            dll_fc_init = 1'($urandom);
            dll_typ = 2'($urandom);
            dll_hdr_creds = HW'($urandom);
            dll_data_creds = DW'($urandom);
            tlp_req_valid = 1'($urandom);
            tlp_req_typ = 2'($urandom);
            tlp_req_data_creds = RW'($urandom);
            @(negedge clk);
            n_chk++;
            if ({tlp_req_ready, fc_init_done, fc_update_error} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset outputs: got %b expected 000",
                         {tlp_req_ready, fc_init_done, fc_update_error});
            end
        end
        @(posedge clk);
        #1;
        {dll_link_up, dll_valid, dll_fc_init, tlp_req_valid} = '0;
        tlp_req_typ = 2'd0;
        tlp_req_data_creds = '0;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        dll_link_up = 1'b1;
        tlp_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if (fc_init_done !== 1'b0 || tlp_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL link_up_no_init: done=%b ready=%b expected 0 0", fc_init_done, tlp_req_ready);
            end
        end
        @(posedge clk);
        #1;
        tlp_req_valid = 1'b0;
    endtask

    task automatic test_init_unscaled();
        fc_init(8, 64, 4, 0, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) tick(1, 2'd0, 16, 1, 0, 0, 0, 0, 0, "p_16");
        tick(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, "p_fifth");
        for (int i = 0; i < 3; i++) tick(1, 2'd1, 5, 1, 0, 0, 0, 0, 0, "np_data_inf");
        for (int i = 0; i < 3; i++) tick(1, 2'd2, 100, 1, 0, 0, 0, 0, 0, "cpl_inf");
    endtask

    task automatic test_update();
        tick(1, 2'd0, 16, 0, 1, 2'd0, 8, 80, 0, "upd_same_cycle_old_limit");
        tick(1, 2'd0, 16, 1, 0, 0, 0, 0, 0, "upd_new_limit");
        tick(0, 2'd0, 0, 0, 1, 2'd0, 8, 32, 1, "upd_data_below_cc");
        tick(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, "upd_limit_kept");
        tick(1, 2'd0, 0, 1, 0, 0, 0, 0, 0, "p_nodata");
        tick(0, 2'd0, 0, 0, 1, 2'd0, 2, 80, 1, "upd_hdr_below_cc");
        tick(1, 2'd0, 0, 1, 0, 0, 0, 0, 0, "p_hdr7");
        tick(1, 2'd0, 0, 1, 0, 0, 0, 0, 0, "p_hdr8");
        tick(1, 2'd0, 0, 0, 0, 0, 0, 0, 0, "p_hdr_exhausted");
        tick(1, 2'd3, 0, 0, 0, 0, 0, 0, 0, "reserved_typ");
    endtask

    task automatic test_scaled();
        drop_link();
        fc_init(3, 0, 0, 0, 0, 0, 2'b10, 2'b00);
        for (int i = 0; i < 12; i++) tick(1, 2'd0, 5, 1, 0, 0, 0, 0, 0, "scaled_hdr");
        tick(1, 2'd0, 5, 0, 0, 0, 0, 0, 0, "scaled_hdr_13th");
        drop_link();
        fc_init(0, 5, 0, 0, 0, 0, 2'b00, 2'b11);
        tick(1, 2'd0, 81, 0, 0, 0, 0, 0, 0, "scaled_data_81");
        tick(1, 2'd0, 80, 1, 0, 0, 0, 0, 0, "scaled_data_80");
        tick(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, "scaled_data_after");
    endtask

    // Absolute counts tracked in the bench; the DUT only sees them modulo 4096
    task automatic test_wrap();
        drop_link();
        fc_init(0, 50, 0, 0, 0, 0, 2'b00, 2'b11);
        upd_ds = 2'b11;
        cons = 0;
        lim = 800;
        for (int i = 0; i < 8; i++) begin
            tick(1, 2'd0, lim - cons + 1, 0, 0, 0, 0, 0, 0, "wrap_false_admit");
            tick(1, 2'd0, lim - cons, 1, 0, 0, 0, 0, 0, "wrap_false_block");
            cons = lim;
            lim += 800;
            tick(0, 2'd0, 0, 0, 1, 2'd0, 0, (lim % 4096) >> 4, 0, "wrap_update");
        end
    endtask

    task automatic test_simultaneous();
        lim = cons + 2560;
        tick(1, 2'd0, 512, 1, 1, 2'd0, 0, (lim % 4096) >> 4, 0, "sim_consume_and_update");
        cons += 512;
        tick(1, 2'd0, 1023, 1, 0, 0, 0, 0, 0, "sim_limit_applied_a");
        tick(1, 2'd0, 1023, 1, 0, 0, 0, 0, 0, "sim_limit_applied_b");
        tick(1, 2'd0, 3, 0, 0, 0, 0, 0, 0, "sim_over_by_one");
        tick(1, 2'd0, 2, 1, 0, 0, 0, 0, 0, "sim_exact");
        tick(0, 2'd0, 0, 0, 1, 2'd0, 0, ((lim + 2064) % 4096) >> 4, 1, "sim_past_half");
        tick(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, "sim_limit_kept");
        upd_ds = 2'b00;
    endtask

    task automatic test_link_loss();
        dll_link_up = 1'b0;
        tick(1, 2'd2, 7, 1, 0, 0, 0, 0, 0, "loss_same_cycle");
        n_chk++;
        if (fc_init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_done_lag: got %b expected 1", fc_init_done);
        end
        tick(1, 2'd2, 7, 0, 0, 0, 0, 0, 0, "loss_ready_low");
        n_chk++;
        if (fc_init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_done_low: got %b expected 0", fc_init_done);
        end
    endtask

    task automatic test_reinit();
        fc_init(4, 32, 1, 1, 1, 1, 2'b00, 2'b00);
        tick(1, 2'd0, 16, 1, 0, 0, 0, 0, 0, "reinit_p_a");
        tick(1, 2'd0, 16, 1, 0, 0, 0, 0, 0, "reinit_p_b");
        tick(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, "reinit_p_full");
        tick(1, 2'd1, 1, 1, 0, 0, 0, 0, 0, "reinit_np");
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0, "reinit_np_hdr_full");
        tick(1, 2'd2, 2, 0, 0, 0, 0, 0, 0, "reinit_cpl_data");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_unscaled();
        test_update();
        test_scaled();
        test_wrap();
        test_simultaneous();
        test_link_loss();
        test_reinit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
